qspi_parallelizer: RTL and testbench



---
 rtl/qspi_parallelizer_pkg.sv | 34 +++
 rtl/qspi_parallelizer_if.sv | 29 ++
 rtl/qspi_parallelizer_collector.sv | 52 +++++
 rtl/qspi_parallelizer.sv | 175 +++++++++++++++++
 tb/tb_qspi_parallelizer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/qspi_parallelizer_pkg.sv
// Shared widths, derived counts, state encoding and nibble type for the
// QSPI parallelizer. Optional debug watchers are enabled by PARALLELIZER_DEBUG_EN.
package parallelizer_pkg;

    localparam int KEY_WIDTH          = 64;
    localparam int ENCRYPTER_WIDTH    = 32;
    localparam int NUM_ENCRYPTERS     = 4;
    localparam int KEY_ROTATION_WIDTH = 6;

    localparam int KEY_QSPI_COUNT       = KEY_WIDTH / 4;
    localparam int ENCRYPTER_QSPI_COUNT = ENCRYPTER_WIDTH / 4;
    localparam int KEY_ENCRYPTER_COUNT  = KEY_WIDTH / ENCRYPTER_WIDTH;

    // Counter width for a count, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int KEY_INDEX_W     = cnt_w(KEY_QSPI_COUNT);
    localparam int KEY_ENC_INDEX_W = cnt_w(KEY_ENCRYPTER_COUNT);
    localparam int DATA_INDEX_W    = cnt_w(ENCRYPTER_QSPI_COUNT);
    localparam int ENC_INDEX_W     = cnt_w(NUM_ENCRYPTERS);

    typedef logic [3:0] qspi_nibble_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RECV_KEY  = 3'd1,
        SEND_KEY  = 3'd2,
        RECV_DATA = 3'd3,
        SEND_DATA = 3'd4
    } state_t;

endpackage

// File: rtl/qspi_parallelizer_if.sv
// QSPI receive side and encrypter-bank side of the parallelizer, bundled.
interface qspi_parallelizer_if;
    import parallelizer_pkg::*;

    qspi_nibble_t                                           qspi_data;
    logic                                                   qspi_sending;
    logic                                                   qspi_ready;
    logic                                                   prog;
    logic [NUM_ENCRYPTERS-1:0][ENCRYPTER_WIDTH-1:0]         encrypters_data;
    logic [NUM_ENCRYPTERS-1:0][KEY_ROTATION_WIDTH-1:0]      encrypters_key_rotation;
    logic [NUM_ENCRYPTERS-1:0]                              encrypters_program;
    logic [NUM_ENCRYPTERS-1:0]                              encrypters_data_ready;
    logic [NUM_ENCRYPTERS-1:0]                              encrypters_ready;

    // Parallelizer side
    modport slave (
        input  qspi_data, qspi_sending, prog, encrypters_ready,
        output qspi_ready, encrypters_data, encrypters_key_rotation,
               encrypters_program, encrypters_data_ready
    );

    // QSPI source / encrypter bank side
    modport master (
        output qspi_data, qspi_sending, prog, encrypters_ready,
        input  qspi_ready, encrypters_data, encrypters_key_rotation,
               encrypters_program, encrypters_data_ready
    );

endinterface

// File: rtl/qspi_parallelizer_collector.sv
// Nibble shift register: first nibble ends in the MSBs, index counts nibbles,
// done flags the nibble that completes the word.
module qspi_shift_collector
    import parallelizer_pkg::*;
#(
    parameter int COUNT = 8,
    parameter int IDX_W = cnt_w(COUNT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_i,
    input  logic                 shift_i,
    input  qspi_nibble_t         nibble_i,
    output logic [4*COUNT-1:0]   data_o,
    output logic [IDX_W-1:0]     index_o,
    output logic                 done_o
);

    localparam int W = 4 * COUNT;

    logic [W-1:0]     data_q, data_d;
    logic [IDX_W-1:0] index_q, index_d;

    assign done_o  = shift_i && (index_q == IDX_W'(COUNT - 1));
    assign data_o  = data_q;
    assign index_o = index_q;

    // Clear wins over shift; the index wraps to zero on the completing nibble.
    always_comb begin
        data_d  = data_q;
        index_d = index_q;
        if (clear_i) begin
            data_d  = '0;
            index_d = '0;
        end else if (shift_i) begin
            data_d  = {data_q[W-5:0], nibble_i};
            index_d = done_o ? '0 : index_q + IDX_W'(1);
        end
    end

    // Word and index registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            index_q <= '0;
        end else begin
            data_q  <= data_d;
            index_q <= index_d;
        end
    end

endmodule

// File: rtl/qspi_parallelizer.sv
// QSPI-to-encrypter-bank distributor: key load/broadcast and round-robin
// packet dispatch. Define PARALLELIZER_DEBUG_EN to expose internal registers.
module qspi_parallelizer
    import parallelizer_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    qspi_parallelizer_if.slave            bus
`ifdef PARALLELIZER_DEBUG_EN
    ,
    output logic [2:0]                    state_out,
    output logic [KEY_WIDTH-1:0]          key_out,
    output logic [KEY_ROTATION_WIDTH-1:0] key_rotation_out,
    output logic [KEY_INDEX_W-1:0]        key_index_out,
    output logic [KEY_ENC_INDEX_W-1:0]    key_encrypter_index_out,
    output logic [ENCRYPTER_WIDTH-1:0]    encrypter_data_packet_out,
    output logic [DATA_INDEX_W-1:0]       encrypter_data_index_out,
    output logic [ENC_INDEX_W-1:0]        encrypter_index_out
`endif
);

    state_t                                            state_q, state_d;
    logic [KEY_ENC_INDEX_W-1:0]                        kei_q, kei_d;
    logic [ENC_INDEX_W-1:0]                            ptr_q, ptr_d;
    logic [KEY_ROTATION_WIDTH-1:0]                     rot_q, rot_d;
    logic [NUM_ENCRYPTERS-1:0][ENCRYPTER_WIDTH-1:0]    lane_data_q, lane_data_d;
    logic [NUM_ENCRYPTERS-1:0][KEY_ROTATION_WIDTH-1:0] lane_rot_q, lane_rot_d;
    logic [NUM_ENCRYPTERS-1:0]                         program_q, program_d;
    logic [NUM_ENCRYPTERS-1:0]                         data_ready_q, data_ready_d;

    logic [KEY_WIDTH-1:0]       key_data;
    logic [KEY_INDEX_W-1:0]     key_index;
    logic                       key_done;
    logic [ENCRYPTER_WIDTH-1:0] pkt_data;
    logic [DATA_INDEX_W-1:0]    pkt_index;
    logic                       pkt_done;
    logic [ENCRYPTER_WIDTH-1:0] key_chunk;

    logic consume;
    logic key_shift;
    logic pkt_shift;
    logic dispatch;

    assign bus.qspi_ready = (state_q == IDLE) || (state_q == RECV_KEY) || (state_q == RECV_DATA);

    // prog suppresses any nibble presented in the same cycle.
    assign consume   = bus.qspi_sending && bus.qspi_ready && !bus.prog;
    assign key_shift = consume && (state_q == RECV_KEY);
    assign pkt_shift = consume && ((state_q == IDLE) || (state_q == RECV_DATA));
    assign dispatch  = !bus.prog && (state_q == SEND_DATA) && bus.encrypters_ready[ptr_q];

    // Chunk 0 is the most significant slice of the key.
    assign key_chunk = ENCRYPTER_WIDTH'(key_data >>
                       ((KEY_ENCRYPTER_COUNT - 1 - int'(kei_q)) * ENCRYPTER_WIDTH));

    qspi_shift_collector #(.COUNT(KEY_QSPI_COUNT), .IDX_W(KEY_INDEX_W)) u_key (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (bus.prog),
        .shift_i  (key_shift),
        .nibble_i (bus.qspi_data),
        .data_o   (key_data),
        .index_o  (key_index),
        .done_o   (key_done)
    );

    qspi_shift_collector #(.COUNT(ENCRYPTER_QSPI_COUNT), .IDX_W(DATA_INDEX_W)) u_pkt (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (bus.prog || dispatch),
        .shift_i  (pkt_shift),
        .nibble_i (bus.qspi_data),
        .data_o   (pkt_data),
        .index_o  (pkt_index),
        .done_o   (pkt_done)
    );

    // Next-state and lane outputs; program/data_ready default low so they pulse.
    always_comb begin
        state_d      = state_q;
        kei_d        = kei_q;
        ptr_d        = ptr_q;
        rot_d        = rot_q;
        lane_data_d  = lane_data_q;
        lane_rot_d   = lane_rot_q;
        program_d    = '0;
        data_ready_d = '0;
        if (bus.prog) begin
            state_d = RECV_KEY;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pkt_shift) state_d = RECV_DATA;
                end
                RECV_KEY: begin
                    if (key_done) begin
                        state_d = SEND_KEY;
                        kei_d   = '0;
                    end
                end
                SEND_KEY: begin
                    lane_data_d = {NUM_ENCRYPTERS{key_chunk}};
                    program_d   = '1;
                    if (kei_q == KEY_ENC_INDEX_W'(KEY_ENCRYPTER_COUNT - 1)) begin
                        kei_d      = '0;
                        rot_d      = '0;
                        ptr_d      = '0;
                        lane_rot_d = '0;
                        state_d    = IDLE;
                    end else begin
                        kei_d = kei_q + KEY_ENC_INDEX_W'(1);
                    end
                end
                RECV_DATA: begin
                    if (pkt_done) state_d = SEND_DATA;
                end
                SEND_DATA: begin
                    if (dispatch) begin
                        lane_data_d[ptr_q]  = pkt_data;
                        lane_rot_d[ptr_q]   = rot_q;
                        data_ready_d[ptr_q] = 1'b1;
                        ptr_d   = (ptr_q == ENC_INDEX_W'(NUM_ENCRYPTERS - 1)) ? '0
                                                                              : ptr_q + ENC_INDEX_W'(1);
                        rot_d   = rot_q + KEY_ROTATION_WIDTH'(1);
                        state_d = RECV_DATA;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control and lane registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            kei_q        <= '0;
            ptr_q        <= '0;
            rot_q        <= '0;
            lane_data_q  <= '0;
            lane_rot_q   <= '0;
            program_q    <= '0;
            data_ready_q <= '0;
        end else begin
            state_q      <= state_d;
            kei_q        <= kei_d;
            ptr_q        <= ptr_d;
            rot_q        <= rot_d;
            lane_data_q  <= lane_data_d;
            lane_rot_q   <= lane_rot_d;
            program_q    <= program_d;
            data_ready_q <= data_ready_d;
        end
    end

    assign bus.encrypters_data         = lane_data_q;
    assign bus.encrypters_key_rotation = lane_rot_q;
    assign bus.encrypters_program      = program_q;
    assign bus.encrypters_data_ready   = data_ready_q;

`ifdef PARALLELIZER_DEBUG_EN
    assign state_out                 = state_q;
    assign key_out                   = key_data;
    assign key_rotation_out          = rot_q;
    assign key_index_out             = key_index;
    assign key_encrypter_index_out   = kei_q;
    assign encrypter_data_packet_out = pkt_data;
    assign encrypter_data_index_out  = pkt_index;
    assign encrypter_index_out       = ptr_q;
`else
    logic unused_idx;
    assign unused_idx = ^{key_index, pkt_index};
`endif

endmodule

// File: tb/tb_qspi_parallelizer.sv
// Bench for qspi_parallelizer: packet table + scoreboard queue, plus
// hand sequences for key load, stalls, pauses, prog discard and async reset.
module tb_qspi_parallelizer;
    import parallelizer_pkg::*;

    typedef struct {
        logic [31:0] pkt;
        int          lane;
        logic [5:0]  rot;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    qspi_parallelizer_if bus();

`ifdef PARALLELIZER_DEBUG_EN
    logic [2:0]                    dbg_state;
    logic [KEY_WIDTH-1:0]          dbg_key;
    logic [KEY_ROTATION_WIDTH-1:0] dbg_rot;
    logic [KEY_INDEX_W-1:0]        dbg_kidx;
    logic [KEY_ENC_INDEX_W-1:0]    dbg_keidx;
    logic [ENCRYPTER_WIDTH-1:0]    dbg_pkt;
    logic [DATA_INDEX_W-1:0]       dbg_didx;
    logic [ENC_INDEX_W-1:0]        dbg_eidx;
`endif

    qspi_parallelizer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef PARALLELIZER_DEBUG_EN
        ,
        .state_out                 (dbg_state),
        .key_out                   (dbg_key),
        .key_rotation_out          (dbg_rot),
        .key_index_out             (dbg_kidx),
        .key_encrypter_index_out   (dbg_keidx),
        .encrypter_data_packet_out (dbg_pkt),
        .encrypter_data_index_out  (dbg_didx),
        .encrypter_index_out       (dbg_eidx)
`endif
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   stalls = 0;
    vec_t tbl[11];
    vec_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every data_ready pulse must match the oldest expected packet.
    always @(negedge clk) begin
        if (!reset && bus.encrypters_data_ready != '0) begin
            for (int l = 0; l < NUM_ENCRYPTERS; l++) begin
                if (bus.encrypters_data_ready[l]) begin
                    n_vec++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_pulse: lane %0d data %h, no packet expected", l,
                                 bus.encrypters_data[l]);
                    end else begin
                        vec_t e;
                        e = sb.pop_front();
                        if (l != e.lane || bus.encrypters_data[l] !== e.pkt ||
                            bus.encrypters_key_rotation[l] !== e.rot) begin
                            n_err++;
                            $display("FAIL dispatch: got lane %0d data %h rot %0d, expected lane %0d data %h rot %0d",
                                     l, bus.encrypters_data[l], bus.encrypters_key_rotation[l],
                                     e.lane, e.pkt, e.rot);
                        end
                    end
                end
            end
        end
    end

    // Present one nibble and hold it until accepted; called just after a negedge.
    task automatic send_nib(input logic [3:0] n);
        int waited = 0;
        bus.qspi_data    = n;
        bus.qspi_sending = 1'b1;
        while (!bus.qspi_ready) begin
            stalls++;
            @(negedge clk);
            waited++;
            if (waited > 100) begin
                n_vec++;
                n_err++;
                $display("FAIL nibble_accept: qspi_ready %b after %0d cycles, required 1", bus.qspi_ready, waited);
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int first, input int cnt);
        for (int i = first; i < first + cnt; i++) begin
            logic [31:0] t;
            t = w << (4 * i);
            send_nib(t[31:28]);
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        bus.qspi_sending = 1'b0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic key_load(input logic [63:0] k);
        int t = 0;
        bus.prog         = 1'b1;
        bus.qspi_sending = 1'b1;
        bus.qspi_data    = 4'hF;   // must be ignored while prog is high
        @(negedge clk);
        bus.prog = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [63:0] s;
            s = k << (4 * i);
            send_nib(s[63:60]);
        end
        bus.qspi_sending = 1'b0;
        while (bus.encrypters_program == '0 && t < 8) begin
            @(negedge clk);
            t++;
        end
        check("key_chunk0_program", 64'(bus.encrypters_program), 64'hF);
        for (int l = 0; l < NUM_ENCRYPTERS; l++)
            check("key_chunk0_data", 64'(bus.encrypters_data[l]), 64'(k[63:32]));
        @(negedge clk);
        check("key_chunk1_program", 64'(bus.encrypters_program), 64'hF);
        for (int l = 0; l < NUM_ENCRYPTERS; l++)
            check("key_chunk1_data", 64'(bus.encrypters_data[l]), 64'(k[31:0]));
        check("key_done_qspi_ready", 64'(bus.qspi_ready), 64'd1);
        @(negedge clk);
        check("key_done_program_low", 64'(bus.encrypters_program), 64'd0);
        check("key_done_rotations", 64'(bus.encrypters_key_rotation), 64'd0);
    endtask

    initial begin
        tbl[0]  = '{32'hABCDEF01, 0, 6'd0};
        tbl[1]  = '{32'h11223344, 0, 6'd0};
        tbl[2]  = '{32'h55667788, 1, 6'd1};
        tbl[3]  = '{32'h99AABBCC, 2, 6'd2};
        tbl[4]  = '{32'hDDEEFF00, 3, 6'd3};
        tbl[5]  = '{32'h0F1E2D3C, 0, 6'd4};
        tbl[6]  = '{32'h13579BDF, 1, 6'd5};
        tbl[7]  = '{32'h2468ACE1, 2, 6'd6};
        tbl[8]  = '{32'h0C0FFEE5, 0, 6'd0};
        tbl[9]  = '{32'h5A5A5A5A, 1, 6'd1};
        tbl[10] = '{32'h87654321, 0, 6'd0};

        bus.qspi_data        = '0;
        bus.qspi_sending     = 1'b0;
        bus.prog             = 1'b0;
        bus.encrypters_ready = '1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_qspi_ready", 64'(bus.qspi_ready), 64'd1);
        check("rst_program", 64'(bus.encrypters_program), 64'd0);
        check("rst_data_ready", 64'(bus.encrypters_data_ready), 64'd0);
        check("rst_lane_data", 64'(bus.encrypters_data[0] | bus.encrypters_data[3]), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Key load and broadcast
        key_load(64'h123456789ABCDEF0);

        // Single packet, all lanes ready
        sb.push_back(tbl[0]);
        send_word(tbl[0].pkt, 0, 8);
        drain("drain_single");
        check("lane1_holds_key_chunk", 64'(bus.encrypters_data[1]), 64'h9ABCDEF0);

        // Fresh key, then 40 nibbles streamed back to back
        key_load(64'h0123456789ABCDEF);
        stalls = 0;
        for (int i = 1; i <= 5; i++) begin
            sb.push_back(tbl[i]);
            send_word(tbl[i].pkt, 0, 8);
        end
        drain("drain_stream");
        check("stream_send_data_stalls", 64'(stalls), 64'd4);

        // Lane 1 not ready: block must wait without dispatching or accepting
        bus.encrypters_ready = 4'b1101;
        sb.push_back(tbl[6]);
        send_word(tbl[6].pkt, 0, 8);
        bus.qspi_sending = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("wait_qspi_ready", 64'(bus.qspi_ready), 64'd0);
            check("wait_no_pulse", 64'(bus.encrypters_data_ready), 64'd0);
        end
        bus.encrypters_ready = 4'b1111;
        drain("drain_wait");

        // qspi_sending dropped mid-packet, resumed three cycles later
        sb.push_back(tbl[7]);
        send_word(tbl[7].pkt, 0, 5);
        bus.qspi_sending = 1'b0;
        repeat (3) @(negedge clk);
        check("pause_no_pulse", 64'(bus.encrypters_data_ready), 64'd0);
        send_word(tbl[7].pkt, 5, 3);
        drain("drain_pause");

        // prog during RECV_DATA discards the partial packet
        send_nib(4'hD);
        send_nib(4'hE);
        send_nib(4'hA);
        key_load(64'hFEDCBA9876543210);
        sb.push_back(tbl[8]);
        send_word(tbl[8].pkt, 0, 8);
        drain("drain_after_prog");

        // Asynchronous reset while waiting in SEND_DATA
        bus.encrypters_ready = 4'b1101;
        send_word(tbl[9].pkt, 0, 8);
        bus.qspi_sending = 1'b0;
        @(negedge clk);
        check("send_data_qspi_ready", 64'(bus.qspi_ready), 64'd0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_qspi_ready", 64'(bus.qspi_ready), 64'd1);
        check("async_rst_data_ready", 64'(bus.encrypters_data_ready), 64'd0);
        check("async_rst_program", 64'(bus.encrypters_program), 64'd0);
        check("async_rst_lane0", 64'(bus.encrypters_data[0]), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.encrypters_ready = 4'b1111;
        @(negedge clk);

        // Asynchronous reset mid-RECV_DATA drops the partial packet
        send_nib(4'h7);
        send_nib(4'h7);
        send_nib(4'h7);
        bus.qspi_sending = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_recv_qspi_ready", 64'(bus.qspi_ready), 64'd1);
        check("rst_recv_data_ready", 64'(bus.encrypters_data_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        sb.push_back(tbl[10]);
        send_word(tbl[10].pkt, 0, 8);
        drain("drain_after_reset");
        check("lane1_cleared_by_reset", 64'(bus.encrypters_data[1]), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
